// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: data/history sizing, stream terminator and the
// decoder FSM state type. The encoder side imports the same package.
package lz77_pkg;

    localparam int DATA_W       = 8;
    localparam int SEARCH_DEPTH = 9;
    localparam int POS_W        = 4;
    localparam int LEN_W        = 3;

    localparam logic [DATA_W-1:0] END_CHAR = 8'h24;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT,
        DONE
    } state_e;

    // True when a match offset addresses a real history slot.
    function automatic logic pos_in_range(input logic [POS_W-1:0] pos);
        return pos < POS_W'(SEARCH_DEPTH);
    endfunction

endpackage

// File: rtl/lz77_decoder_if.sv
// Code-triple input stream and decoded-byte output stream of the LZ77 decoder.
// master: code source / byte sink side; slave: the decoder.
interface lz77_decoder_if
    import lz77_pkg::*;
();

    logic              code_valid;
    logic              code_ready;
    logic [POS_W-1:0]  code_pos;
    logic [LEN_W-1:0]  code_len;
    logic [DATA_W-1:0] code_char;
    logic              char_valid;
    logic              char_ready;
    logic [DATA_W-1:0] char_nxt;

    modport master (
        output code_valid, code_pos, code_len, code_char, char_ready,
        input  code_ready, char_valid, char_nxt
    );

    modport slave (
        input  code_valid, code_pos, code_len, code_char, char_ready,
        output code_ready, char_valid, char_nxt
    );

endinterface

// File: rtl/lz77_hist_buf.sv
// History shift register of the last SEARCH_DEPTH output bytes.
// Slot 0 is the most recent byte; out-of-range reads return 0.
module lz77_hist_buf
    import lz77_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    input  logic [POS_W-1:0]  rd_pos,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] hist_q [SEARCH_DEPTH];
    logic [DATA_W-1:0] hist_d [SEARCH_DEPTH];

    // Shift a new byte into slot 0 when enabled, otherwise hold.
    always_comb begin
        for (int i = 0; i < SEARCH_DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (shift_en) begin
            hist_d[0] = din;
            for (int i = 1; i < SEARCH_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // History register; cleared by reset so unfilled slots read 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    // Combinational read port addressed by the latched match offset.
    always_comb begin
        rd_data = '0;
        if (pos_in_range(rd_pos)) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                if (rd_pos == POS_W'(i)) begin
                    rd_data = hist_q[i];
                end
            end
        end
    end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 decoder: accepts (pos, len, literal) triples and emits len history
// copies followed by the literal. Optional macro LZ77_DEC_POSCHK_EN adds a
// history fill counter and a sticky pos_err flag for offsets into unfilled
// history.
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    lz77_decoder_if.slave bus,
    output logic          finish
`ifdef LZ77_DEC_POSCHK_EN
    ,
    output logic          pos_err
`endif
);

    state_e            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] lit_q, lit_d;
    logic [DATA_W-1:0] last_q, last_d;

    logic              code_ready;
    logic              char_valid;
    logic [DATA_W-1:0] char_out;
    logic              shift_en;
    logic              accept;
    logic [DATA_W-1:0] hist_rd;

    lz77_hist_buf u_hist (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (char_out),
        .rd_pos   (pos_q),
        .rd_data  (hist_rd)
    );

    // Next-state, triple latching and output byte selection.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        len_d      = len_q;
        lit_d      = lit_q;
        code_ready = 1'b0;
        char_valid = 1'b0;
        char_out   = last_q;
        shift_en   = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted.
                code_ready = reset;
                if (bus.code_valid && code_ready) begin
                    accept  = 1'b1;
                    pos_d   = bus.code_pos;
                    len_d   = bus.code_len;
                    lit_d   = bus.code_char;
                    state_d = (bus.code_len != '0) ? COPY : LIT;
                end
            end
            COPY: begin
                char_valid = 1'b1;
                char_out   = hist_rd;
                if (bus.char_ready) begin
                    shift_en = 1'b1;
                    len_d    = len_q - 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        state_d = LIT;
                    end
                end
            end
            LIT: begin
                char_valid = 1'b1;
                char_out   = lit_q;
                if (bus.char_ready) begin
                    shift_en = 1'b1;
                    state_d  = (lit_q == END_CHAR) ? DONE : IDLE;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
        last_d = char_out;
    end

    // Control state and the held output byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Triple registers; only meaningful after an accept, so not reset.
    always_ff @(posedge clk) begin
        pos_q <= pos_d;
        len_q <= len_d;
        lit_q <= lit_d;
    end

`ifdef LZ77_DEC_POSCHK_EN
    logic [POS_W-1:0] fill_q, fill_d;
    logic             pos_err_q, pos_err_d;

    // Count emitted bytes up to SEARCH_DEPTH; flag copies reaching past them.
    always_comb begin
        fill_d    = fill_q;
        pos_err_d = pos_err_q;
        if (shift_en && (fill_q < POS_W'(SEARCH_DEPTH))) begin
            fill_d = fill_q + 1'b1;
        end
        if (accept && (bus.code_len != '0) && (bus.code_pos >= fill_q)) begin
            pos_err_d = 1'b1;
        end
    end

    // Fill counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q    <= '0;
            pos_err_q <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            pos_err_q <= pos_err_d;
        end
    end

    assign pos_err = pos_err_q;
`endif

    assign bus.code_ready = code_ready;
    assign bus.char_valid = char_valid;
    assign bus.char_nxt   = char_out;
    assign finish         = (state_q == DONE);

endmodule
